// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the fetch / load-store memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
  function automatic logic arb_grant(input logic [1:0] rv, input logic last);
    case (rv)
      2'b01:   return PORT_IF;
      2'b10:   return PORT_LS;
      default: return ~last;
    endcase
  endfunction

  function automatic logic [1:0] port_onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the shared memory port.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic          req_we1;
  logic [DW-1:0] req_wdata1;
  logic [1:0]    rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          mem_sel;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  req_valid, req_addr0, req_addr1, req_we1, req_wdata1,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output mem_sel, mem_valid, mem_addr, mem_we, mem_wdata
  );

  // Requesters plus memory view.
  modport master (
    output req_valid, req_addr0, req_addr1, req_we1, req_wdata1,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  mem_sel, mem_valid, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_mux2to1.sv
// Plain N-bit 2:1 mux used for the memory address and write-data paths.
module mux2to1 #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic         sel,
  output logic [N-1:0] y
);
  assign y = sel ? in1 : in0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (port 0) and load/store (port 1),
// locking each transaction until the memory responds or the watchdog aborts it.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input logic                clk,
  input logic                reset_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  state_t        state;
  logic          last;
  logic          sel_q;
  logic          we_q;
  logic [CW-1:0] wd_cnt;
  logic [AW-1:0] addr0_q;
  logic [AW-1:0] addr1_q;
  logic [DW-1:0] wdata1_q;

  logic pend, grant, in_req, in_wait, hit, tmo, done, load;

  assign pend    = |bus.req_valid;
  assign grant   = arb_grant(bus.req_valid, last);
  assign in_req  = (state == REQ);
  assign in_wait = (state == WAIT);
  assign hit     = in_wait & bus.mem_rvalid;
  assign tmo     = in_wait & ~bus.mem_rvalid & (wd_cnt == CW'(TIMEOUT - 1));
  assign done    = hit | tmo;
  assign load    = pend & ((state == IDLE) | done);

  // Request fields are captured at grant so the memory side stays stable through WAIT.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      last     <= 1'b1;
      sel_q    <= PORT_IF;
      we_q     <= 1'b0;
      wd_cnt   <= '0;
      addr0_q  <= '0;
      addr1_q  <= '0;
      wdata1_q <= '0;
    end else begin
      if (load) begin
        sel_q    <= grant;
        last     <= grant;
        we_q     <= grant & bus.req_we1;
        addr0_q  <= bus.req_addr0;
        addr1_q  <= bus.req_addr1;
        wdata1_q <= bus.req_wdata1;
      end
      case (state)
        IDLE: if (pend) state <= REQ;
        REQ: begin
          if (bus.mem_ready) begin
            state  <= WAIT;
            wd_cnt <= '0;
          end
        end
        WAIT: begin
          if (done) state <= pend ? REQ : IDLE;
          else      wd_cnt <= wd_cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  mux2to1 #(.N(AW)) u_addr_mux (
    .in0 (addr0_q),
    .in1 (addr1_q),
    .sel (sel_q),
    .y   (bus.mem_addr)
  );

  // Port 0 never writes, so its data leg is tied off.
  mux2to1 #(.N(DW)) u_wdata_mux (
    .in0 ('0),
    .in1 (wdata1_q),
    .sel (sel_q),
    .y   (bus.mem_wdata)
  );

  // Handshake strobes are suppressed while reset is asserted so a dropped transaction never responds.
  assign bus.mem_sel   = sel_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_valid = reset_n & in_req;
  assign bus.req_ready = {2{reset_n & in_req & bus.mem_ready}} & port_onehot(sel_q);
  assign bus.rsp_valid = {2{reset_n & done}} & port_onehot(sel_q);
  assign bus.rsp_err   = reset_n & tmo;
  assign bus.rsp_rdata = hit ? bus.mem_rdata : '0;

endmodule
